mem_access_unit: RTL and testbench

- MEM-stage initiator for the word-organised data memory. It converts pipeline load/store requests (byte, halfword, word) into word-aligned memory transactions.
- Sub-word stores are performed as read-modify-write.
- Load data is lane-extracted and sign- or zero-extended.
- It stalls the pipeline until the access completes and flags misaligned accesses without touching memory.

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage initiator turning byte/half/word loads and stores into word-aligned memory accesses.
// Latency: word store 2, load 1+READ_LATENCY, sub-word store 2+READ_LATENCY, misaligned 1 cycle to done.
// Backpressure: stall holds the pipeline while req_valid is high until the DONE/ERR cycle.
module mem_access_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] load_data,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        store_q, store_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [29:0] mem_word_q, mem_word_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;

  logic        req_misal;
  logic        read_last;
  logic [31:0] merged;
  logic [31:0] extracted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign load_data      = load_data_q;
  assign mem_address    = {mem_word_q, 2'b00};
  assign mem_write_data = mem_write_data_q;
  assign read_last      = (state_q == S_READ) && (cnt_q == 4'd0);

  // Classify the incoming request: illegal size or offset not aligned to the access size
  always_comb begin
    req_misal = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (|req_addr[1:0]));
  end

  // Merge the store lane into the word read back from memory
  always_comb begin
    merged = mem_read_data;
    case (size_q)
      2'b00: begin
        case (addr_lo_q)
          2'd0: merged[7:0]   = wdata_q[7:0];
          2'd1: merged[15:8]  = wdata_q[7:0];
          2'd2: merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_lo_q[1]) merged[31:16] = wdata_q[15:0];
        else              merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Select the load lane and extend it to 32 bits
  always_comb begin
    case (addr_lo_q)
      2'd0: lane_b = mem_read_data[7:0];
      2'd1: lane_b = mem_read_data[15:8];
      2'd2: lane_b = mem_read_data[23:16];
      default: lane_b = mem_read_data[31:24];
    endcase
    lane_h = addr_lo_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (size_q)
      2'b00:   extracted = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   extracted = {{16{signed_q & lane_h[15]}}, lane_h};
      default: extracted = mem_read_data;
    endcase
  end

  // State register and all datapath flops, synchronous reset aborts any access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      addr_lo_q        <= 2'd0;
      size_q           <= 2'd0;
      signed_q         <= 1'b0;
      store_q          <= 1'b0;
      wdata_q          <= 32'd0;
      load_data_q      <= 32'd0;
      mem_word_q       <= 30'd0;
      mem_write_data_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      addr_lo_q        <= addr_lo_d;
      size_q           <= size_d;
      signed_q         <= signed_d;
      store_q          <= store_d;
      wdata_q          <= wdata_d;
      load_data_q      <= load_data_d;
      mem_word_q       <= mem_word_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // Next-state and wait counter: word stores skip the read, everything else reads first
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_misal) begin
            state_d = S_ERR;
          end else if (req_store && (req_size == 2'b10)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) state_d = store_q ? S_WRITE : S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture on acceptance; read data lands in load_data or the write word
  always_comb begin
    addr_lo_d        = addr_lo_q;
    size_d           = size_q;
    signed_d         = signed_q;
    store_d          = store_q;
    wdata_d          = wdata_q;
    load_data_d      = load_data_q;
    mem_word_d       = mem_word_q;
    mem_write_data_d = mem_write_data_q;
    if ((state_q == S_IDLE) && req_valid) begin
      addr_lo_d = req_addr[1:0];
      size_d    = req_size;
      signed_d  = req_signed;
      store_d   = req_store;
      wdata_d   = req_wdata;
      // A rejected request must not disturb the memory-side bus
      if (!req_misal) begin
        mem_word_d = req_addr[31:2];
        if (req_store && (req_size == 2'b10)) mem_write_data_d = req_wdata;
      end
    end
    if (read_last) begin
      if (store_q) mem_write_data_d = merged;
      else         load_data_d      = extracted;
    end
  end

  // Moore outputs decoded from state; stall drops only in the completion cycle
  always_comb begin
    mem_write  = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      S_WRITE: mem_write = 1'b1;
      S_DONE:  done      = 1'b1;
      S_ERR: begin
        done       = 1'b1;
        misaligned = 1'b1;
      end
      default: ;
    endcase
    stall = req_valid && !((state_q == S_DONE) || (state_q == S_ERR));
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit with a word memory model.
// The driver predicts each access into a scoreboard; the monitor checks at negedge.
// Reset behaviour and final memory contents are checked through probe requests.
module tb_mem_access_unit;

  localparam int RL = 3;

  localparam int P_RST     = 1;
  localparam int P_ABORT   = 2;
  localparam int P_SWEEP   = 3;
  localparam int P_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  mem_access_unit #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .misaligned(misaligned), .load_data(load_data),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          issue;
    int          lat;
    bit          misal;
    logic [31:0] ld;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb_q[$];
  int          probe_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] model_mem [0:63];
  logic [31:0] last_ld;
  logic        clr_mem;
  int          cyc = 0;
  int          total_writes = 0;
  int          abort_snap;
  int          n_pass = 0;
  int          n_total = 0;
  int          wr_cnt = 0;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else if (mem_write) begin
      mem[mem_address[7:2]] <= mem_write_data;
      total_writes <= total_writes + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                           input logic [1:0] sz, input bit sg);
    logic [31:0] v;
    v = w >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int off,
                                            input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mask = mask << (8 * off);
    return (w & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // Monitor: probes, write checks, stall, and scoreboard pop on done
  always @(negedge clk) begin
    exp_t e;
    int p;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      case (p)
        P_RST: begin
          chk("rst_stall", {31'd0, stall}, 32'd0);
          chk("rst_done", {31'd0, done}, 32'd0);
          chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
          chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
          chk("rst_load_data", load_data, 32'd0);
          chk("rst_mem_address", mem_address, 32'd0);
          chk("rst_mem_write_data", mem_write_data, 32'd0);
        end
        P_ABORT: begin
          chk("abort_stall", {31'd0, stall}, 32'd0);
          chk("abort_done", {31'd0, done}, 32'd0);
          chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
          chk("abort_write_count", total_writes, abort_snap);
          chk("abort_mem_word", mem[16], model_mem[16]);
        end
        P_SWEEP: begin
          for (int i = 0; i < 64; i++) chk("mem_sweep", mem[i], model_mem[i]);
        end
        default: chk("done_timeout", 32'd0, 32'd1);
      endcase
    end
    if (!reset) begin
      if (mem_write) begin
        wr_cnt++;
        if (sb_q.size() > 0) begin
          chk("write_addr", mem_address, sb_q[0].waddr);
          chk("write_data", mem_write_data, sb_q[0].wdata);
        end else begin
          chk("unexpected_write", 32'd1, 32'd0);
        end
      end
      chk("stall", {31'd0, stall}, {31'd0, req_valid && !done});
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("misaligned", {31'd0, misaligned}, {31'd0, e.misal});
          chk("load_data", load_data, e.ld);
          chk("latency", cyc - e.issue, e.lat);
          chk("writes_per_op", wr_cnt, e.nwr);
        end
        wr_cnt = 0;
      end
    end
  end

  // Issue one request (called #1 after a posedge), predict it, wait for done
  task automatic do_req(input bit st, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   off;
    int   idx;
    bit   got;
    off = int'(a[1:0]);
    idx = int'(a[7:2]);
    e.issue = cyc;
    e.misal = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    e.nwr   = 0;
    e.waddr = 32'd0;
    e.wdata = 32'd0;
    if (e.misal) begin
      e.lat = 1;
    end else if (!st) begin
      e.lat   = 1 + RL;
      last_ld = ref_load(model_mem[idx], off, sz, sg);
    end else begin
      e.lat          = (sz == 2'd2) ? 2 : 2 + RL;
      model_mem[idx] = ref_store(model_mem[idx], off, sz, wd);
      e.nwr          = 1;
      e.waddr        = {a[31:2], 2'b00};
      e.wdata        = model_mem[idx];
    end
    e.ld = last_ld;
    sb_q.push_back(e);
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      probe_q.push_back(P_TIMEOUT);
      sb_q.delete();
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    reset      = 1'b1;
    clr_mem    = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    last_ld    = 32'd0;
    abort_snap = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    idle(3);
    probe_q.push_back(P_RST);
    idle(1);
    reset   = 1'b0;
    clr_mem = 1'b0;
    idle(1);

    // Word store then word load of the same address
    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);
    // Byte store merge into a known word
    do_req(1, 2'd2, 0, 32'h10, 32'h11223344);
    do_req(1, 2'd0, 0, 32'h12, 32'hAA);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);
    // Lane extraction with sign and zero extension
    do_req(1, 2'd2, 0, 32'h20, 32'h8000F07F);
    do_req(0, 2'd0, 1, 32'h20, 32'h0);
    do_req(0, 2'd0, 0, 32'h21, 32'h0);
    do_req(0, 2'd0, 1, 32'h21, 32'h0);
    do_req(0, 2'd1, 1, 32'h22, 32'h0);
    do_req(0, 2'd1, 0, 32'h22, 32'h0);
    // Halfword store into the upper lane
    do_req(1, 2'd1, 0, 32'h22, 32'h1234ABCD);
    do_req(0, 2'd2, 0, 32'h20, 32'h0);
    // Misaligned and illegal requests
    do_req(0, 2'd1, 1, 32'h23, 32'h0);
    do_req(1, 2'd2, 0, 32'h26, 32'h55555555);
    do_req(0, 2'd3, 0, 32'h30, 32'h0);
    idle(2);

    // Reset during the read phase of a byte store
    do_req(1, 2'd2, 0, 32'h40, 32'hCAFEF00D);
    abort_snap = total_writes;
    req_store  = 1'b1;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h41;
    req_wdata  = 32'h000000EE;
    req_valid  = 1'b1;
    idle(2);
    reset     = 1'b1;
    req_valid = 1'b0;
    idle(1);
    probe_q.push_back(P_ABORT);
    idle(1);
    reset   = 1'b0;
    last_ld = 32'd0;
    idle(RL + 2);
    probe_q.push_back(P_ABORT);
    idle(1);
    do_req(0, 2'd2, 0, 32'h40, 32'h0);

    // Randomized traffic with occasional back-to-back requests
    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    probe_q.push_back(P_SWEEP);
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
